// File: rtl/qspi_ram_target_if.sv
// qspi_ram_target_if
//   Groups the quad-SPI pins between an initiator and the RAM target.
//   Signals:
//     spi_clk      initiator clock (sampled by the target's system clock)
//     spi_select   chip select, active-low
//     spi_data_in  quad data from initiator to target
//     spi_data_out quad data from target to initiator
//     spi_data_oe  output enables for spi_data_out (all bits equal)
//     busy         target is inside a transaction
//   Modports:
//     master  initiator side (drives clock, select and data_in)
//     slave   target side (drives data_out, oe and busy)
interface qspi_ram_target_if;
  logic       spi_clk;
  logic       spi_select;
  logic [3:0] spi_data_in;
  logic [3:0] spi_data_out;
  logic [3:0] spi_data_oe;
  logic       busy;

  modport master (
    output spi_clk,
    output spi_select,
    output spi_data_in,
    input  spi_data_out,
    input  spi_data_oe,
    input  busy
  );

  modport slave (
    input  spi_clk,
    input  spi_select,
    input  spi_data_in,
    output spi_data_out,
    output spi_data_oe,
    output busy
  );
endinterface

// File: rtl/qspi_ram_target.sv
// qspi_ram_target
//   Quad-SPI slave that fronts a 2^ADDR_BITS byte array. Supports fast read
//   (0x0B, 24-bit address, DUMMY_CYCLES dummy rises) and page-less write
//   (0x02, 24-bit address). Bursts are unlimited and wrap modulo the array
//   size; a transaction ends only when spi_select goes high.
//   Ports:
//     clk  system clock, all state updates on its rising edge
//     rst  asynchronous reset, active-high (array contents are kept)
//     bus  qspi_ram_target_if.slave pin bundle
module qspi_ram_target #(
  parameter int ADDR_BITS    = 8,
  parameter int DUMMY_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  qspi_ram_target_if.slave     bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DUMMY  = 3'd3;
  localparam logic [2:0] ST_READ   = 3'd4;
  localparam logic [2:0] ST_WRITE  = 3'd5;
  localparam logic [2:0] ST_IGNORE = 3'd6;

  // The nibble counter doubles as the dummy-rise counter, so widen it only
  // when the dummy count would not fit in three bits.
  localparam int CNT_W = (DUMMY_CYCLES > 7) ? $clog2(DUMMY_CYCLES + 1) : 3;

  logic [2:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [23:0]      addr_r;
  logic [7:0]       shift_r;
  logic [7:0]       wdata_r;
  logic             wr_pend_r;
  logic             is_write_r;
  logic             armed_r;
  logic             spi_clk_r;
  logic [3:0]       data_out_r;
  logic             oe_r;
  logic             busy_r;

  logic [7:0]       mem_r [2**ADDR_BITS];

  logic             rise_s;
  logic             fall_s;
  logic [7:0]       cmd_s;
  logic [7:0]       rd_byte_s;

  // Edge decode and read-port lookup
  always_comb begin
    rise_s    = bus.spi_clk & ~spi_clk_r;
    fall_s    = ~bus.spi_clk & spi_clk_r;
    cmd_s     = {shift_r[3:0], bus.spi_data_in};
    rd_byte_s = mem_r[addr_r[ADDR_BITS-1:0]];
  end

  // Protocol FSM, address/nibble bookkeeping and registered pin outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      addr_r     <= 24'h000000;
      shift_r    <= 8'h00;
      wdata_r    <= 8'h00;
      wr_pend_r  <= 1'b0;
      is_write_r <= 1'b0;
      armed_r    <= 1'b0;
      spi_clk_r  <= 1'b0;
      data_out_r <= 4'h0;
      oe_r       <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      spi_clk_r <= bus.spi_clk;

      // A completed write byte commits one cycle after its second nibble,
      // even if select rises in that cycle: only partial bytes are dropped.
      if (wr_pend_r) begin
        wr_pend_r <= 1'b0;
        addr_r    <= addr_r + 24'd1;
      end

      if (bus.spi_select) begin
        // Seeing select high re-arms the target after a reset.
        state_r <= ST_IDLE;
        cnt_r   <= '0;
        oe_r    <= 1'b0;
        busy_r  <= 1'b0;
        armed_r <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (armed_r) begin
              state_r <= ST_CMD;
              cnt_r   <= '0;
              busy_r  <= 1'b1;
            end
          end
          ST_CMD: begin
            if (rise_s) begin
              shift_r <= cmd_s;
              if (cnt_r == CNT_W'(1)) begin
                cnt_r <= '0;
                case (cmd_s)
                  8'h0B: begin
                    state_r    <= ST_ADDR;
                    is_write_r <= 1'b0;
                  end
                  8'h02: begin
                    state_r    <= ST_ADDR;
                    is_write_r <= 1'b1;
                  end
                  default: state_r <= ST_IGNORE;
                endcase
              end else begin
                cnt_r <= cnt_r + CNT_W'(1);
              end
            end
          end
          ST_ADDR: begin
            if (rise_s) begin
              addr_r <= {addr_r[19:0], bus.spi_data_in};
              if (cnt_r == CNT_W'(5)) begin
                cnt_r <= '0;
                if (is_write_r) begin
                  state_r <= ST_WRITE;
                end else if (DUMMY_CYCLES == 0) begin
                  state_r <= ST_READ;
                end else begin
                  state_r <= ST_DUMMY;
                end
              end else begin
                cnt_r <= cnt_r + CNT_W'(1);
              end
            end
          end
          ST_DUMMY: begin
            if (rise_s) begin
              if (cnt_r == CNT_W'(DUMMY_CYCLES - 1)) begin
                cnt_r   <= '0;
                state_r <= ST_READ;
              end else begin
                cnt_r <= cnt_r + CNT_W'(1);
              end
            end
          end
          ST_READ: begin
            // cnt_r[0] selects which half of the current byte goes out next.
            if (fall_s) begin
              oe_r <= 1'b1;
              if (!cnt_r[0]) begin
                data_out_r <= rd_byte_s[7:4];
                cnt_r      <= CNT_W'(1);
              end else begin
                data_out_r <= rd_byte_s[3:0];
                cnt_r      <= '0;
                addr_r     <= addr_r + 24'd1;
              end
            end
          end
          ST_WRITE: begin
            if (rise_s) begin
              if (!cnt_r[0]) begin
                shift_r <= {4'h0, bus.spi_data_in};
                cnt_r   <= CNT_W'(1);
              end else begin
                wdata_r   <= cmd_s;
                wr_pend_r <= 1'b1;
                cnt_r     <= '0;
              end
            end
          end
          ST_IGNORE: begin
            oe_r <= 1'b0;
          end
          default: begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            oe_r    <= 1'b0;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Byte array write port; deliberately outside reset so contents persist
  always_ff @(posedge clk) begin
    if (wr_pend_r) begin
      mem_r[addr_r[ADDR_BITS-1:0]] <= wdata_r;
    end
  end

  assign bus.spi_data_out = data_out_r;
  assign bus.spi_data_oe  = {4{oe_r}};
  assign bus.busy         = busy_r;

endmodule

// File: tb/tb_qspi_ram_target.sv
// tb_qspi_ram_target
//   Directed bench for qspi_ram_target (ADDR_BITS = 8, DUMMY_CYCLES = 4).
//   Inputs change on the falling edge of clk; outputs are sampled there too.
module tb_qspi_ram_target;
  logic clk;
  logic rst;
  int   checks;
  int   passes;

  qspi_ram_target_if bus ();

  qspi_ram_target #(
    .ADDR_BITS   (8),
    .DUMMY_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rise(input logic [3:0] n);
    bus.spi_data_in = n;
    bus.spi_clk     = 1'b1;
    tick(2);
  endtask

  task automatic fall();
    bus.spi_clk = 1'b0;
    tick(2);
  endtask

  task automatic nib(input logic [3:0] n);
    rise(n);
    fall();
  endtask

  task automatic send_byte(input logic [7:0] b);
    nib(b[7:4]);
    nib(b[3:0]);
  endtask

  task automatic start(input logic [7:0] cmd, input logic [23:0] a);
    bus.spi_select = 1'b0;
    tick(2);
    send_byte(cmd);
    for (int i = 5; i >= 0; i--) nib(a[i*4 +: 4]);
  endtask

  task automatic stop();
    bus.spi_select = 1'b1;
    bus.spi_clk    = 1'b0;
    tick(2);
  endtask

  // Leaves the target in READ right after the last dummy rise.
  task automatic read_start(input logic [23:0] a);
    start(8'h0B, a);
    for (int i = 0; i < 4; i++) begin
      rise(4'h0);
      if (i < 3) fall();
    end
  endtask

  task automatic read_chk(input string tag, input logic [3:0] exp);
    fall();
    chk(tag, {4'h0, bus.spi_data_out}, {4'h0, exp});
    chk({tag, "_oe"}, {4'h0, bus.spi_data_oe}, 8'h0F);
    rise(4'h0);
  endtask

  initial begin
    checks          = 0;
    passes          = 0;
    rst             = 1'b1;
    bus.spi_clk     = 1'b0;
    bus.spi_select  = 1'b1;
    bus.spi_data_in = 4'h0;
    tick(2);
    chk("rst_out", {4'h0, bus.spi_data_out}, 8'h00);
    chk("rst_oe", {4'h0, bus.spi_data_oe}, 8'h00);
    chk("rst_busy", {7'h00, bus.busy}, 8'h00);
    rst = 1'b0;
    tick(2);

    // Write A5 3C at 0x10, then read it back
    start(8'h02, 24'h000010);
    chk("wr_busy", {7'h00, bus.busy}, 8'h01);
    send_byte(8'hA5);
    send_byte(8'h3C);
    stop();
    read_start(24'h000010);
    chk("rd_oe_pre", {4'h0, bus.spi_data_oe}, 8'h00);
    read_chk("rd0", 4'hA);
    read_chk("rd1", 4'h5);
    read_chk("rd2", 4'h3);
    read_chk("rd3", 4'hC);
    stop();

    // Wrap at the top of the array
    start(8'h02, 24'h0000FF);
    send_byte(8'h11);
    send_byte(8'h22);
    stop();
    read_start(24'h0000FF);
    read_chk("wrap0", 4'h1);
    read_chk("wrap1", 4'h1);
    read_chk("wrap2", 4'h2);
    read_chk("wrap3", 4'h2);
    stop();

    // Unknown command: oe stays low, array untouched
    start(8'h9F, 24'h000010);
    for (int i = 0; i < 5; i++) begin
      nib(4'hF);
      chk("ign_oe", {4'h0, bus.spi_data_oe}, 8'h00);
    end
    chk("ign_busy", {7'h00, bus.busy}, 8'h01);
    stop();
    read_start(24'h000010);
    read_chk("ign_mem0", 4'hA);
    read_chk("ign_mem1", 4'h5);
    stop();

    // Partial write byte is dropped on deselect
    start(8'h02, 24'h000020);
    send_byte(8'h5A);
    stop();
    start(8'h02, 24'h000020);
    nib(4'hF);
    bus.spi_select = 1'b1;
    tick(1);
    chk("part_busy", {7'h00, bus.busy}, 8'h00);
    tick(1);
    read_start(24'h000020);
    read_chk("part0", 4'h5);
    read_chk("part1", 4'hA);
    stop();

    // Reset during the read data phase
    read_start(24'h000010);
    read_chk("rr0", 4'hA);
    rst = 1'b1;
    #1;
    chk("rr_oe", {4'h0, bus.spi_data_oe}, 8'h00);
    chk("rr_out", {4'h0, bus.spi_data_out}, 8'h00);
    tick(2);
    rst         = 1'b0;
    bus.spi_clk = 1'b0;
    tick(2);
    send_byte(8'h0B);
    chk("rr_nostart", {7'h00, bus.busy}, 8'h00);
    stop();
    read_start(24'h000010);
    read_chk("rr_a", 4'hA);
    read_chk("rr_b", 4'h5);
    read_chk("rr_c", 4'h3);
    read_chk("rr_d", 4'hC);
    stop();

    // Address bits above ADDR_BITS are ignored
    start(8'h02, 24'hABCD42);
    send_byte(8'h77);
    stop();
    read_start(24'h000042);
    read_chk("hi0", 4'h7);
    read_chk("hi1", 4'h7);
    stop();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
